// File: rtl/tt_cpu_host_loader.sv
// Host-side driver for the nibble-serial CPU bus: queues commands, replays each one with a
// self-generated slow target clock, and returns the target output captured after RUNPROG.
//
// state     | meaning
// RESET_TGT | tgt_rst high while RST_PERIODS target-clock periods are generated
// IDLE      | waiting for a command; stalls while an unconsumed result is pending
// LOW       | new bus value visible, tgt_clk low for HALF cycles
// HIGH      | tgt_clk high for HALF cycles; RUNPROG captures tgt_out on the last one
module tt_cpu_host_loader #(
   parameter int DEPTH       = 4,
   parameter int HALF        = 2,
   parameter int RST_PERIODS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_data,
   output logic       tgt_clk,
   output logic       tgt_rst,
   output logic [1:0] tgt_instr,
   output logic [3:0] tgt_data,
   input  logic [7:0] tgt_out,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic       busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int RW = (RST_PERIODS > 1) ? $clog2(RST_PERIODS) : 1;
   localparam logic [PW-1:0] PH_LAST  = PW'(HALF - 1);
   localparam logic [RW-1:0] PER_LAST = RW'(RST_PERIODS - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [1:0]    OP_RUNPROG = 2'd3;

   typedef enum logic [1:0] {S_RESET_TGT, S_IDLE, S_LOW, S_HIGH} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [RW-1:0] period_q, period_d;
   logic          tgt_clk_q, tgt_clk_d;
   logic          tgt_rst_q, tgt_rst_d;
   logic [1:0]    tgt_instr_q, tgt_instr_d;
   logic [3:0]    tgt_data_q, tgt_data_d;
   logic          res_valid_q, res_valid_d;
   logic [7:0]    res_data_q, res_data_d;
   logic          busy_q, busy_d;

   logic [5:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          full, push, pop, pending;
   logic [5:0]    head;

   assign full      = (count_q == FULL_CNT);
   assign push      = cmd_valid && !full;
   assign head      = mem_q[rd_ptr_q];
   assign pending   = res_valid_q && !res_ready;

   assign cmd_ready = !full;
   assign tgt_clk   = tgt_clk_q;
   assign tgt_rst   = tgt_rst_q;
   assign tgt_instr = tgt_instr_q;
   assign tgt_data  = tgt_data_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign busy      = busy_q;

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      period_d    = period_q;
      tgt_clk_d   = tgt_clk_q;
      tgt_rst_d   = tgt_rst_q;
      tgt_instr_d = tgt_instr_q;
      tgt_data_d  = tgt_data_q;
      res_valid_d = pending;
      res_data_d  = res_data_q;
      pop         = 1'b0;
      case (state_q)
         S_RESET_TGT: begin
            if (phase_q == PH_LAST) begin
               phase_d = '0;
               if (!tgt_clk_q) begin
                  tgt_clk_d = 1'b1;
               end else if (period_q == PER_LAST) begin
                  tgt_clk_d = 1'b0;
                  tgt_rst_d = 1'b0;
                  state_d   = S_IDLE;
               end else begin
                  tgt_clk_d = 1'b0;
                  period_d  = period_q + RW'(1);
               end
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         S_IDLE: begin
            if (count_q != '0 && !pending) begin
               pop         = 1'b1;
               tgt_instr_d = head[5:4];
               tgt_data_d  = head[3:0];
               phase_d     = '0;
               state_d     = S_LOW;
            end
         end
         S_LOW: begin
            if (phase_q == PH_LAST) begin
               phase_d   = '0;
               tgt_clk_d = 1'b1;
               state_d   = S_HIGH;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         default: begin
            if (phase_q == PH_LAST) begin
               phase_d   = '0;
               tgt_clk_d = 1'b0;
               state_d   = S_IDLE;
               // IDLE never pops while a result is pending, so this cannot overwrite one
               if (tgt_instr_q == OP_RUNPROG) begin
                  res_valid_d = 1'b1;
                  res_data_d  = tgt_out;
               end
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
      endcase
      count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
      busy_d  = (state_d != S_IDLE) || (count_d != '0) || res_valid_d;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RESET_TGT;
         phase_q     <= '0;
         period_q    <= '0;
         tgt_clk_q   <= 1'b0;
         tgt_rst_q   <= 1'b1;
         tgt_instr_q <= '0;
         tgt_data_q  <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         busy_q      <= 1'b1;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         period_q    <= period_d;
         tgt_clk_q   <= tgt_clk_d;
         tgt_rst_q   <= tgt_rst_d;
         tgt_instr_q <= tgt_instr_d;
         tgt_data_q  <= tgt_data_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         busy_q      <= busy_d;
         count_q     <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

endmodule

// File: tb/tb_tt_cpu_host_loader.sv
// Scoreboard bench for tt_cpu_host_loader: bus words and results are queued on issue and
// checked by negedge monitors; directed checks cover reset, timing, stalls and abort.
module tb_tt_cpu_host_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = '0;
   logic [3:0] cmd_data = '0;
   logic       tgt_clk, tgt_rst;
   logic [1:0] tgt_instr;
   logic [3:0] tgt_data;
   logic [7:0] tgt_out = '0;
   logic       res_valid;
   logic       res_ready = 1'b1;
   logic [7:0] res_data;
   logic       busy;

   tt_cpu_host_loader #(.DEPTH(4), .HALF(2), .RST_PERIODS(2)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .tgt_clk(tgt_clk), .tgt_rst(tgt_rst),
      .tgt_instr(tgt_instr), .tgt_data(tgt_data), .tgt_out(tgt_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   logic [5:0] exp_bus [$];
   logic [7:0] exp_res [$];
   int         rise_cyc [$];
   logic       prev_clk = 1'b0;
   logic [5:0] eb;
   logic [7:0] er;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // bus monitor: every rising target clock outside target reset presents one command
   always @(negedge clk) begin
      if (tgt_rst === 1'b0 && prev_clk === 1'b0 && tgt_clk === 1'b1) begin
         rise_cyc.push_back(cyc);
         if (exp_bus.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL bus_unexpected actual=%0h required=none", {tgt_instr, tgt_data});
         end else begin
            eb = exp_bus.pop_front();
            chk("bus_word", {26'd0, tgt_instr, tgt_data}, {26'd0, eb});
         end
      end
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
         if (exp_res.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL res_unexpected actual=%0h required=none", res_data);
         end else begin
            er = exp_res.pop_front();
            chk("res_data", {24'd0, res_data}, {24'd0, er});
         end
      end
      prev_clk = tgt_clk;
   end

   task automatic push(input logic [1:0] op, input logic [3:0] d, input bit exp_b,
                       input bit exp_r, input logic [7:0] rv);
      bit ok;
      int n;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 100) begin
         @(negedge clk);
         ok = cmd_ready;
         @(posedge clk);
         #1;
         n++;
      end
      cmd_valid = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL push_timeout actual=not_accepted required=accepted op=%0d", op);
      end else begin
         if (exp_b) exp_bus.push_back({op, d});
         if (exp_r) exp_res.push_back(rv);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy !== 1'b0 && n < 300);
      chk("idle_reached", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_res_valid();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (res_valid !== 1'b1 && n < 100);
      chk("res_valid_seen", {31'd0, res_valid}, 32'd1);
   endtask

   initial begin
      logic [7:0] pat_rst;
      logic [4:0] pat_cmd;
      int n;
      pat_rst = 8'b1100_1100;
      pat_cmd = 5'b0_1100;

      // reset release: 8 cycles of tgt_rst with clock 0,0,1,1,0,0,1,1
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rst_tgt_rst", {31'd0, tgt_rst}, 32'd1);
         chk("rst_tgt_clk", {31'd0, tgt_clk}, {31'd0, pat_rst[i]});
         if (i == 0) begin
            chk("rst_busy", {31'd0, busy}, 32'd1);
            chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
            chk("rst_res_data", {24'd0, res_data}, 32'd0);
            chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
         end
      end
      @(negedge clk);
      chk("rel_tgt_rst", {31'd0, tgt_rst}, 32'd0);
      chk("rel_tgt_clk", {31'd0, tgt_clk}, 32'd0);
      chk("rel_busy", {31'd0, busy}, 32'd0);
      chk("rel_bus", {26'd0, tgt_instr, tgt_data}, 32'd0);
      @(posedge clk);
      #1;

      // single LOADPROG 0xA while idle
      push(2'd0, 4'hA, 1'b1, 1'b0, 8'h00);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) chk("single_bus", {26'd0, tgt_instr, tgt_data}, 32'h0A);
         chk("single_clk", {31'd0, tgt_clk}, {31'd0, pat_cmd[i]});
      end
      chk("single_busy", {31'd0, busy}, 32'd0);
      chk("single_res_valid", {31'd0, res_valid}, 32'd0);
      @(posedge clk);
      #1;

      // five back-to-back pushes while the target is held in reset
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      rise_cyc.delete();
      push(2'd1, 4'h1, 1'b1, 1'b0, 8'h00);
      push(2'd2, 4'h2, 1'b1, 1'b0, 8'h00);
      push(2'd0, 4'h3, 1'b1, 1'b0, 8'h00);
      push(2'd1, 4'h4, 1'b1, 1'b0, 8'h00);
      @(negedge clk);
      chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk);
      #1;
      push(2'd2, 4'h5, 1'b1, 1'b0, 8'h00);
      wait_idle();
      chk("b2b_count", rise_cyc.size(), 32'd5);
      if (rise_cyc.size() == 5)
         for (int i = 1; i < 5; i++)
            chk("b2b_spacing", rise_cyc[i] - rise_cyc[i-1], 32'd5);

      // RUNPROG with a stalled consumer blocks the following LOADDATA
      res_ready = 1'b0;
      tgt_out   = 8'h3C;
      push(2'd3, 4'h7, 1'b1, 1'b1, 8'h3C);
      push(2'd1, 4'h5, 1'b1, 1'b0, 8'h00);
      wait_res_valid();
      repeat (6) @(negedge clk);
      chk("stall_bus", {26'd0, tgt_instr, tgt_data}, 32'h37);
      chk("stall_res_valid", {31'd0, res_valid}, 32'd1);
      chk("stall_res_data", {24'd0, res_data}, 32'h3C);
      chk("stall_busy", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1 res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      chk("unstall_bus", {26'd0, tgt_instr, tgt_data}, 32'h15);
      chk("unstall_res_valid", {31'd0, res_valid}, 32'd0);
      wait_idle();

      // two RUNPROGs with the consumer always ready
      res_ready = 1'b1;
      tgt_out   = 8'h11;
      push(2'd3, 4'h1, 1'b1, 1'b1, 8'h11);
      push(2'd3, 4'h2, 1'b1, 1'b1, 8'h22);
      wait_res_valid();
      @(posedge clk);
      #1 tgt_out = 8'h22;
      wait_idle();
      chk("res_all_seen", exp_res.size(), 32'd0);

      // reset during the HIGH phase of a RUNPROG with two commands queued
      tgt_out = 8'h99;
      push(2'd3, 4'hF, 1'b1, 1'b0, 8'h00);
      push(2'd0, 4'h1, 1'b0, 1'b0, 8'h00);
      push(2'd1, 4'h2, 1'b0, 1'b0, 8'h00);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tgt_clk !== 1'b1 && n < 50);
      chk("abort_high_seen", {31'd0, tgt_clk}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_tgt_clk", {31'd0, tgt_clk}, 32'd0);
      chk("abort_tgt_rst", {31'd0, tgt_rst}, 32'd1);
      chk("abort_res_valid", {31'd0, res_valid}, 32'd0);
      chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      rise_cyc.delete();
      wait_idle();
      repeat (10) @(negedge clk);
      chk("abort_no_replay", rise_cyc.size(), 32'd0);
      chk("abort_bus", {26'd0, tgt_instr, tgt_data}, 32'd0);
      chk("abort_res_none", {31'd0, res_valid}, 32'd0);
      chk("bus_all_seen", exp_bus.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/tt_cpu_host_loader.md
Name: tt_cpu_host_loader

Overview:
- Host-side driver for the nibble-serial CPU input bus. That bus is an 8-bit word: {data[3:0], instr[1:0], rst, clk}.
- Accepts queued commands over a valid/ready interface. Instructions: LOADPROG=0, LOADDATA=1, SETRUNPT=2, RUNPROG=3.
- Replays each command onto the bus with a self-generated, slow target clock.
- Captures the target's 8-bit output after every RUNPROG step and returns it over a valid/ready result port.

Parameters:
- DEPTH, 4, command FIFO entries. Power of two, at least 2.
- HALF, 2, system cycles per target-clock phase. At least 1; target period = 2*HALF.
- RST_PERIODS, 2, number of full target-clock periods with tgt_rst held high after rst.

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_op  in  2  instruction code
- cmd_data  in  4  data nibble
- tgt_clk  out  1  generated target clock (registered data signal)
- tgt_rst  out  1  target reset
- tgt_instr  out  2  instruction field to target
- tgt_data  out  4  data field to target
- tgt_out  in  8  target output bus
- res_valid  out  1  captured result available
- res_ready  in  1  result consumer ready
- res_data  out  8  captured tgt_out
- busy  out  1  high unless in IDLE with FIFO empty and res_valid=0

Behaviour:
- All outputs are registered.
- Reset (rst=1 at an edge) sets:
  - FIFO empty; state RESET_TGT; phase counter 0; period counter 0.
  - tgt_clk=0, tgt_rst=1, tgt_instr=0, tgt_data=0.
  - res_valid=0, res_data=0, busy=1.
- Reset mid-command aborts the command and discards all FIFO contents and any pending result.
- FIFO:
  - Push on cmd_valid && cmd_ready. cmd_ready=!full at all times, including RESET_TGT.
  - Pop only from IDLE when the FIFO is non-empty (registered occupancy). There is no fall-through, so a push into an empty FIFO is popped no earlier than the next cycle.
  - Pointers wrap modulo DEPTH. The count is one bit wider than the pointers.
- State RESET_TGT:
  - tgt_clk toggles every HALF cycles, starting low, for RST_PERIODS full periods.
  - On the cycle that would start period RST_PERIODS+1: tgt_rst becomes 0, tgt_clk stays 0, go to IDLE.
- State IDLE:
  - Pop the head entry only if the FIFO is non-empty and no result is pending. A result is pending when res_valid=1 and this cycle is not a consuming handshake.
  - On pop: register op and data into tgt_instr and tgt_data; the new values are visible the next cycle. Go to LOW.
- State LOW:
  - tgt_clk=0 for HALF cycles, counting the first cycle in which the new bus value is visible.
  - Then go to HIGH.
- State HIGH:
  - tgt_clk=1 for HALF cycles.
  - On the last HIGH cycle, if the op is RUNPROG: res_data<=tgt_out and res_valid<=1.
  - Then tgt_clk<=0 and go to IDLE.
- Bus hold: tgt_instr and tgt_data keep the last command's values until the next pop; they never return to zero between commands.
- Back-to-back commands:
  - An IDLE cycle with a pop immediately follows HIGH, so the bus change is visible 1 cycle after tgt_clk falls.
  - Steady-state command spacing is 2*HALF+1 cycles.
- Latency: a command pushed at edge t (FIFO empty, IDLE) is popped at edge t+1. The bus is visible from cycle t+1 through HALF cycles. tgt_clk rises HALF cycles later.
- Result port:
  - res_valid clears on res_valid && res_ready.
  - If a new capture coincides with a handshake, the new value wins and res_valid stays 1.
  - Results are never overwritten unconsumed, because IDLE stalls while a result is pending.
- tgt_rst=0 everywhere outside RESET_TGT.

Test Plan:
- Reset release, HALF=2, RST_PERIODS=2:
  - tgt_rst=1 for 8 cycles, with tgt_clk pattern 0,0,1,1,0,0,1,1.
  - Then tgt_rst=0, busy=0, tgt_instr=0, tgt_data=0.
- Single LOADPROG data=0xA pushed while idle:
  - tgt_instr=0, tgt_data=0xA from the cycle after the pop.
  - tgt_clk low for 2 cycles, then high for 2.
  - res_valid stays 0; busy returns to 0.
- Push 5 commands back-to-back, DEPTH=4, consumer stalled in RESET_TGT:
  - cmd_ready drops after the 4th push; the 5th is held.
  - All 5 commands appear on the bus in order, with bus changes 5 cycles apart.
- RUNPROG with tgt_out=0x3C, res_ready=0:
  - res_valid=1, res_data=0x3C.
  - A following queued LOADDATA does not start until res_ready=1 for one cycle; it then pops in that cycle.
- RUNPROG twice with res_ready=1 throughout and tgt_out changing 0x11 then 0x22:
  - Two res_valid pulses with res_data 0x11, then 0x22.
- rst asserted during the HIGH phase of a RUNPROG with 2 entries queued:
  - Next cycle: tgt_clk=0, tgt_rst=1, res_valid=0, cmd_ready=1.
  - No queued command is replayed after RESET_TGT completes.
